// File: rtl/rr_decode_sched_pkg.sv
// rtl/rr_decode_sched_pkg.sv - shared types, constants and arbitration helper
// Contents:
//   N_REQ, SEL_W       requester count and select width
//   MAX_HOLD_DEFAULT   default forced-release hold limit
//   state_t            scheduler FSM states
//   pick_t / rr_pick   round-robin winner search starting at the pointer
package rr_decode_sched_pkg;

  localparam int unsigned N_REQ            = 8;
  localparam int unsigned SEL_W            = 3;
  localparam int unsigned MAX_HOLD_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set request at ptr, ptr+1, ... with the index wrapping 7 -> 0.
  function automatic pick_t rr_pick(logic [N_REQ-1:0] req, logic [SEL_W-1:0] ptr);
    pick_t            p;
    logic [SEL_W-1:0] idx;
    p.found = 1'b0;
    p.idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (!p.found && req[idx]) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_decode_sched_if.sv
// rtl/rr_decode_sched_if.sv - requester/scheduler handshake bundle
// Signals:
//   req     [7:0]  level request per requester
//   done           single-cycle release pulse from the owner
//   grant   [0:7]  one-hot registered grant
//   sel     [2:0]  index of the current owner (valid while busy)
//   busy           high while a grant is held
//   timeout        one-cycle pulse on forced release
// Modports: master = requester side, slave = scheduler side.
interface rr_decode_sched_if;
  import rr_decode_sched_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [0:N_REQ-1] grant;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             timeout;

  modport master (output req, output done,
                  input  grant, input sel, input busy, input timeout);
  modport slave  (input  req, input  done,
                  output grant, output sel, output busy, output timeout);
endinterface

// File: rtl/rr_decode_sched_sel_decoder.sv
// rtl/rr_decode_sched_sel_decoder.sv - combinational 3-to-8 one-hot decoder
// Ports:
//   in_i   [2:0]  binary select
//   out_o  [0:7]  out_o[k] = 1 when in_i == k
module sel_decoder
  import rr_decode_sched_pkg::*;
(
  input  logic [SEL_W-1:0] in_i,
  output logic [0:N_REQ-1] out_o
);

  always_comb begin
    out_o = '0;
    out_o[in_i] = 1'b1;
  end

endmodule

// File: rtl/rr_decode_sched.sv
// rtl/rr_decode_sched.sv - round-robin owner scheduler for a shared decoded select
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_decode_sched_if.slave (req, done in; grant, sel, busy, timeout out)
// Parameter MAX_HOLD: forced-release limit in GRANT cycles (2..255).
// Optional feature macro: RR_DECODE_SCHED_TIMEOUT_EN enables the hold counter
// and forced release; otherwise timeout is tied low.
module rr_decode_sched
  import rr_decode_sched_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_decode_sched_if.slave    bus
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [0:N_REQ-1] grant_q, grant_d;
  logic             busy_q;
  logic [0:N_REQ-1] dec;
  logic             rel;
  logic             expire;
  pick_t            pick;

  // Decode the next select so grant is a registered copy of it.
  sel_decoder u_sel_decoder (
    .in_i  (sel_d),
    .out_o (dec)
  );

  assign pick = rr_pick(bus.req, ptr_q);
  assign rel  = bus.done | ~bus.req[sel_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE, RELEASE: begin
        if (pick.found) begin
          state_d = GRANT;
          sel_d   = pick.idx;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (rel || expire) begin
          state_d = RELEASE;
          ptr_d   = sel_q + SEL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = (state_d == GRANT) ? dec : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      busy_q  <= (state_d == GRANT);
    end
  end

`ifdef RR_DECODE_SCHED_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  assign expire = (state_q == GRANT) && (hold_q == 8'(MAX_HOLD - 1));

  always_comb begin
    hold_d    = '0;
    timeout_d = 1'b0;
    // Counter restarts on every entry to GRANT and runs while the grant is held.
    if (state_q == GRANT && state_d == GRANT) begin
      hold_d = hold_q + 8'd1;
    end
    // A coincident normal release wins over the expiry.
    if (state_q == GRANT && expire && !rel) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_rr_decode_sched.sv
// tb/tb_rr_decode_sched.sv - directed self-checking bench for rr_decode_sched
module tb_rr_decode_sched;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rr_decode_sched_if bus ();

  rr_decode_sched #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:7] onehot(int k);
    logic [0:7] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(string tag, int owner);
    check({tag, "_grant"}, 32'(bus.grant), 32'(onehot(owner)));
    check({tag, "_sel"}, 32'(bus.sel), 32'(owner));
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic check_idle(string tag);
    check({tag, "_grant0"}, 32'(bus.grant), 32'd0);
    check({tag, "_busy0"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    step();
    step();
    check_idle("reset");
    check("reset_sel", 32'(bus.sel), 32'd0);
    check("reset_timeout", 32'(bus.timeout), 32'd0);

    // Grant owner 0, then async reset in the middle of the grant.
    rst_n   = 1'b1;
    bus.req = 8'hFF;
    step();
    check_grant("first", 0);
    step();
    check_grant("hold0", 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_sel", 32'(bus.sel), 32'd0);
    check("async_rst_timeout", 32'(bus.timeout), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check_grant("post_rst", 0);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    check_idle("post_rst_dead");
    step();

    // Round robin over all eight with done on every 3rd grant cycle.
    for (int i = 0; i < 8; i++) begin
      int owner;
      owner = (1 + i) % 8;
      check_grant($sformatf("rr%0d_c1", owner), owner);
      step();
      check_grant($sformatf("rr%0d_c2", owner), owner);
      step();
      check_grant($sformatf("rr%0d_c3", owner), owner);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      check_idle($sformatf("rr%0d_dead", owner));
      step();
    end
    check_grant("rr_wrap", 1);

    // Owner 1 drops; only 7 requesting.
    bus.req = 8'h80;
    step();
    check_idle("drop1");
    step();
    check_grant("own7", 7);

    // Owner 7 releases with 0 and 2 pending: 0 then 2.
    bus.done = 1'b1;
    bus.req  = 8'h85;
    step();
    bus.done = 1'b0;
    bus.req  = 8'h05;
    check_idle("rel7");
    step();
    check_grant("wrap0", 0);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    step();
    check_grant("then2", 2);

    // Owner 5 drops without done; ptr must be 6 so 6 beats 0.
    bus.req = 8'h20;
    step();
    step();
    check_grant("own5", 5);
    bus.req = 8'h41;
    step();
    check_idle("drop5");
    check("drop5_timeout", 32'(bus.timeout), 32'd0);
    step();
    check_grant("ptr6", 6);

    // Lone requester re-wins after a dead cycle.
    bus.req = 8'h08;
    step();
    step();
    check_grant("lone3", 3);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    check_idle("lone3_dead");
    step();
    check_grant("lone3_again", 3);

    // done in IDLE has no effect.
    bus.req = 8'h00;
    step();
    step();
    check_idle("idle");
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    check_idle("idle_done");

`ifdef RR_DECODE_SCHED_TIMEOUT_EN
    bus.req = 8'h04;
    step();
    for (int c = 1; c <= 4; c++) begin
      check_grant($sformatf("to_c%0d", c), 2);
      check($sformatf("to_c%0d_timeout", c), 32'(bus.timeout), 32'd0);
      step();
    end
    check_idle("to_rel");
    check("to_pulse", 32'(bus.timeout), 32'd1);
    step();
    check_grant("to_regrant", 2);
    check("to_pulse_end", 32'(bus.timeout), 32'd0);
    step();
    step();
    step();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    check_idle("to_done_rel");
    check("to_done_no_pulse", 32'(bus.timeout), 32'd0);
`else
    bus.req = 8'h04;
    step();
    for (int c = 1; c <= 10; c++) begin
      check_grant($sformatf("hold_c%0d", c), 2);
      check($sformatf("hold_c%0d_timeout", c), 32'(bus.timeout), 32'd0);
      step();
    end
`endif
    bus.req = 8'h00;
    step();
    step();
    check_idle("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
